tc_countdown_timer: RTL

TC_COUNTDOWN_TIMER -- requirements
Module: tc_countdown_timer

---
 rtl/tc_countdown_timer_pkg.sv | 11 +
 rtl/tc_countdown_timer.sv | 100 ++++++++++
 2 files changed

// File: rtl/tc_countdown_timer_pkg.sv
// Shared TC package: state encoding for the countdown timer.
//   tc_state_e : 2-bit state of the timer (IDLE / RUN / HOLD)
package tc_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } tc_state_e;

endpackage : tc_countdown_timer_pkg

// File: rtl/tc_countdown_timer.sv
// Countdown timer with reload register, pause/resume and optional periodic
// reload. All outputs are registered except busy, a decode of the state.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   load         capture in into reload register and count, go IDLE
//   in           reload value (BIT_WIDTH)
//   start        begin / resume counting
//   stop         pause counting (only meaningful while running)
//   auto_reload  periodic mode: reload instead of stopping at expiry
//   out          current count (BIT_WIDTH)
//   busy         high while running
//   done         one-cycle expiry pulse
module tc_countdown_timer #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 auto_reload,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 busy,
    output logic                 done
);
    import tc_countdown_timer_pkg::*;

    localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

    tc_state_e            state, state_next;
    logic [BIT_WIDTH-1:0] reload_reg, reload_next;
    logic [BIT_WIDTH-1:0] out_next;
    logic                 done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            out        <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            out        <= out_next;
            reload_reg <= reload_next;
            done       <= done_next;
        end
    end

    // Priority: load > stop > start > countdown. A stop outside RUN has no
    // effect of its own but still masks a simultaneous start. A start while
    // already running is ignored, so the countdown proceeds.
    always_comb begin
        state_next  = state;
        out_next    = out;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (load) begin
            reload_next = in;
            out_next    = in;
            state_next  = ST_IDLE;
        end else if (stop) begin
            if (state == ST_RUN) begin
                state_next = ST_HOLD;
            end
        end else if (start && state != ST_RUN) begin
            if (state == ST_HOLD) begin
                state_next = ST_RUN;
            end else if (out != '0) begin
                state_next = ST_RUN;
            end else if (reload_reg != '0) begin
                out_next   = reload_reg;
                state_next = ST_RUN;
            end else begin
                done_next = 1'b1;
            end
        end else if (state == ST_RUN) begin
            if (out > ONE) begin
                out_next = out - ONE;
            end else if (out == ONE) begin
                done_next = 1'b1;
                if (auto_reload) begin
                    out_next = reload_reg;
                end else begin
                    out_next   = '0;
                    state_next = ST_IDLE;
                end
            end else begin
                // Unreachable in normal use; never count below zero.
                state_next = ST_IDLE;
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule : tc_countdown_timer
